score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the stable-input cycles needed before a sensor change is accepted (10 ms at 100 MHz).
REQ-002 SHALL have parameter LOCKOUT_CYCLES, default 50000000, meaning the per-player ignore window after a scored hit (0.5 s).
REQ-003 SHALL have parameter MAX_SCORE, default 63, meaning the saturation ceiling, which must fit in 6 bits.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse that begins a new game.
REQ-008 clock_stopped  input  1  level from the countdown timer; 1 means time expired.
REQ-009 ir_sensor_p1  input  3  raw asynchronous IR sensors for player 1, active-high on ball detect.
REQ-010 ir_sensor_p2  input  3  the same for player 2.
REQ-011 score_p1  output  6  player 1 score.
REQ-012 score_p2  output  6  player 2 score.
REQ-013 hit_p1  output  1  one-cycle pulse when a player 1 hit is scored.
REQ-014 hit_p2  output  1  one-cycle pulse when a player 2 hit is scored.
REQ-015 winner  output  2  game result: 00 = no result or game running, 01 = P1 wins, 10 = P2 wins, 11 = tie.
REQ-016 state  output  2  current FSM state, for debug.

Function
REQ-017 Each of the 6 sensor bits SHALL pass through a 2-flop synchronizer, then a debouncer.
- Debounced value updates only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Any bounce restarts that bit's count.
REQ-018 A sensor event SHALL be a 0->1 transition of a debounced bit.
REQ-019 Sensor point values SHALL be: bit0 = 1, bit1 = 2, bit2 = 3.
REQ-020 If several sensors of one player event in the same cycle, only the highest-value sensor SHALL score.
REQ-021 The FSM SHALL have three states: IDLE = 00, RUN = 01, DONE = 10.
REQ-022 IDLE->RUN on start; entering RUN SHALL clear both scores and both lockouts.
REQ-023 RUN->DONE on clock_stopped = 1.
REQ-024 DONE->RUN on start, with scores cleared.
REQ-025 start while in RUN SHALL restart the game: scores cleared, state stays RUN.
REQ-026 If start and clock_stopped are both high in the same cycle, start SHALL win and the next state is RUN.
REQ-027 Scoring SHALL occur only in RUN, when the player is not in lockout and clock_stopped = 0.
- Update: score <= min(score + points, MAX_SCORE), registered one cycle after the event.
- hit_px asserts in that same cycle.
REQ-028 A scored hit SHALL load that player's lockout counter with LOCKOUT_CYCLES.
- Events are ignored (no pulse, no score) while the counter is nonzero.
- The two players' lockouts are independent.
REQ-029 Simultaneous P1 and P2 events SHALL both score in the same cycle.
REQ-030 Scores SHALL hold their values in IDLE and DONE.
REQ-031 winner SHALL be valid only in DONE, computed from the final scores, and 00 in all other states.
REQ-032 Saturating arithmetic SHALL use a 7-bit intermediate sum; scores never wrap.

Reset
REQ-033 reset_n low SHALL asynchronously force:
- state = IDLE;
- scores = 0, hit_p1/hit_p2 = 0, winner = 00;
- all debounced bits = 0;
- all counters = 0.
REQ-034 Reset asserted mid-game SHALL discard the game; after release the block waits in IDLE for start.
REQ-035 A sensor held high through reset release SHALL produce an event after DEBOUNCE_CYCLES, which counts only if the block is in RUN.

Structure
REQ-036 The state encodings and point values SHALL live in a shared package, game_pkg, alongside the existing game constants.
REQ-037 A single sub-module ir_debounce SHALL implement the synchronizer, debouncer and rising-edge detect for one bit; score_keeper instantiates it 6 times.
REQ-038 The target implementation size is 150-300 lines total.

Verification
(All scenarios run with DEBOUNCE_CYCLES = 4 and LOCKOUT_CYCLES = 16.)
REQ-039 Scenario A: start, then P1 bit2 held high for 10 cycles -> score_p1 = 3 and one hit_p1 pulse; a P1 bit0 event 5 cycles later is ignored.
REQ-040 Scenario B: after start, P1 bit1 toggles every 2 cycles for 20 cycles -> no event and score_p1 stays 0.
REQ-041 Scenario C: P1 bits 0 and 2 rise in the same cycle while P2 bit1 also rises -> score_p1 = 3, score_p2 = 2, both pulses in the same cycle.
REQ-042 Scenario D: preload P2 to 62 via repeated hits, then a bit2 event -> score_p2 = 63; a further event keeps it at 63.
REQ-043 Scenario E: clock_stopped rises with P1 = 5 and P2 = 5 -> state DONE and winner = 11; a later sensor event leaves scores unchanged; start -> RUN with scores 0 and winner 00.
REQ-044 Scenario F: reset_n is pulsed low mid-RUN with P1 = 7 -> immediate score 0 and IDLE; start and clock_stopped high in the same cycle -> RUN.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared game constants, FSM state/result encodings and scoring helpers.
package game_pkg;
  localparam int SCORE_W = 6;
  localparam int N_SENSORS = 3;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {WIN_NONE = 2'b00, WIN_P1 = 2'b01, WIN_P2 = 2'b10, WIN_TIE = 2'b11} winner_t;
  localparam logic [1:0] PTS_B0 = 2'd1;
  localparam logic [1:0] PTS_B1 = 2'd2;
  localparam logic [1:0] PTS_B2 = 2'd3;
  // Only the most valuable sensor counts when several fire together.
  function automatic logic [1:0] points(input logic [N_SENSORS-1:0] ev);
    return ev[2] ? PTS_B2 : ev[1] ? PTS_B1 : ev[0] ? PTS_B0 : 2'd0;
  endfunction
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [1:0] p,
                                                  input logic [SCORE_W:0] max);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W-1){1'b0}}, p};
    return (sum > max) ? max[SCORE_W-1:0] : sum[SCORE_W-1:0];
  endfunction
endpackage

// File: rtl/ir_debounce.sv
// ir_debounce: 2-flop synchronizer, consecutive-cycle debouncer and rising-edge pulse for one sensor bit.
module ir_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  logic meta_q, sync_q, db_q, db_d, prev_q, diff, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff = sync_q ^ db_q;
    done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    db_d = (diff && done) ? sync_q : db_q;
    cnt_d = (!diff || done) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      db_q <= 1'b0;
      prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
      db_q <= db_d;
      prev_q <= db_q;
      cnt_q <= cnt_d;
    end
  end
  assign rise = db_q & ~prev_q;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: two-player IR hit scoring with debounce, per-player lockout, saturation and game FSM.
module score_keeper
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int MAX_SCORE = 63
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      clock_stopped,
  input  logic [N_SENSORS-1:0]      ir_sensor_p1,
  input  logic [N_SENSORS-1:0]      ir_sensor_p2,
  output logic [SCORE_W-1:0]        score_p1,
  output logic [SCORE_W-1:0]        score_p2,
  output logic                      hit_p1,
  output logic                      hit_p2,
  output logic [1:0]                winner,
  output logic [1:0]                state
);
  localparam int LW = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [SCORE_W:0] MAX7 = (SCORE_W + 1)'(MAX_SCORE);
  localparam logic [LW-1:0] LOCK = LW'(LOCKOUT_CYCLES);
  state_t state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
  logic [LW-1:0] lock1_q, lock1_d, lock2_q, lock2_d;
  logic hit1_q, hit1_d, hit2_q, hit2_d, can1, can2, open;
  logic [2*N_SENSORS-1:0] raw, ev;
  assign raw = {ir_sensor_p2, ir_sensor_p1};
  for (genvar g = 0; g < 2 * N_SENSORS; g++) begin : g_db
    ir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .reset_n(reset_n), .raw(raw[g]), .rise(ev[g])
    );
  end
  always_comb begin
    state_d = start ? RUN : (state_q == RUN && clock_stopped) ? DONE : state_q;
    // A start pulse clears the game, so no hit may land in that same cycle.
    open = state_q == RUN && !start && !clock_stopped;
    can1 = open && lock1_q == '0 && |ev[N_SENSORS-1:0];
    can2 = open && lock2_q == '0 && |ev[2*N_SENSORS-1:N_SENSORS];
    score1_d = start ? '0 : can1 ? sat_add(score1_q, points(ev[N_SENSORS-1:0]), MAX7) : score1_q;
    score2_d = start ? '0 : can2 ? sat_add(score2_q, points(ev[2*N_SENSORS-1:N_SENSORS]), MAX7) : score2_q;
    lock1_d = start ? '0 : can1 ? LOCK : (lock1_q != '0) ? lock1_q - LW'(1) : '0;
    lock2_d = start ? '0 : can2 ? LOCK : (lock2_q != '0) ? lock2_q - LW'(1) : '0;
    hit1_d = can1;
    hit2_d = can2;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      score1_q <= '0;
      score2_q <= '0;
      lock1_q <= '0;
      lock2_q <= '0;
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      lock1_q <= lock1_d;
      lock2_q <= lock2_d;
      hit1_q <= hit1_d;
      hit2_q <= hit2_d;
    end
  end
  assign winner = (state_q != DONE) ? WIN_NONE : (score1_q > score2_q) ? WIN_P1 :
                  (score2_q > score1_q) ? WIN_P2 : WIN_TIE;
  assign state = state_q;
  assign score_p1 = score1_q;
  assign score_p2 = score2_q;
  assign hit_p1 = hit1_q;
  assign hit_p2 = hit2_q;
endmodule
